// File: rtl/write_back_unit.sv
// write_back_unit: single-port register-file write-back with a 2-entry
// pending-load buffer and a load scoreboard (busy bit per register).
// Optional macro WB_BYPASS_EN adds two combinational bypass read ports
// driven from the registered write port.
`ifndef GPR_SIZE
`define GPR_SIZE 4
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module write_back_unit (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [`GPR_SIZE-1:0]     alu_dest,
  input  logic [`DATA_SIZE-1:0]    alu_data,
  input  logic                     load_issue,
  input  logic [`GPR_SIZE-1:0]     load_issue_dest,
  input  logic                     load_valid,
  input  logic [`GPR_SIZE-1:0]     load_dest,
  input  logic [`DATA_SIZE-1:0]    load_data,
  output logic                     write_enable,
  output logic [`GPR_SIZE-1:0]     write_address,
  output logic [`DATA_SIZE-1:0]    write_data,
  output logic [2**`GPR_SIZE-1:0]  busy,
  output logic                     stall
`ifdef WB_BYPASS_EN
  ,
  input  logic [`GPR_SIZE-1:0]     bypass_address0,
  input  logic [`GPR_SIZE-1:0]     bypass_address1,
  output logic                     bypass_hit0,
  output logic                     bypass_hit1,
  output logic [`DATA_SIZE-1:0]    bypass_data0,
  output logic [`DATA_SIZE-1:0]    bypass_data1
`endif
);
  localparam int NREG = 2**`GPR_SIZE;

  logic                               write_enable_q, write_enable_d;
  logic [`GPR_SIZE-1:0]               write_address_q, write_address_d;
  logic [`DATA_SIZE-1:0]              write_data_q, write_data_d;
  logic [NREG-1:0]                    busy_q, busy_d;
  logic [1:0]                         count_q, count_d;
  // entry 0 is always the FIFO head; entries shift down on pop
  logic [1:0][`GPR_SIZE-1:0]          buf_dest_q, buf_dest_d;
  logic [1:0][`DATA_SIZE-1:0]         buf_data_q, buf_data_d;

  logic pop, direct, push;

  // source selection, FIFO update and scoreboard update for the next edge
  always_comb begin
    pop    = !alu_valid && (count_q != 2'd0);
    direct = !alu_valid && (count_q == 2'd0) && load_valid;
    // any load not written directly this cycle must be buffered
    push   = load_valid && !direct;

    write_enable_d  = alu_valid || pop || direct;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    if (alu_valid) begin
      write_address_d = alu_dest;
      write_data_d    = alu_data;
    end else if (pop) begin
      write_address_d = buf_dest_q[0];
      write_data_d    = buf_data_q[0];
    end else if (direct) begin
      write_address_d = load_dest;
      write_data_d    = load_data;
    end

    buf_dest_d = buf_dest_q;
    buf_data_d = buf_data_q;
    count_d    = count_q;
    if (pop) begin
      buf_dest_d[0] = buf_dest_q[1];
      buf_data_d[0] = buf_data_q[1];
      buf_dest_d[1] = '0;
      buf_data_d[1] = '0;
      count_d       = count_q - 2'd1;
    end
    // a push into a full buffer without a pop is dropped
    if (push && (count_d != 2'd2)) begin
      buf_dest_d[count_d[0]] = load_dest;
      buf_data_d[count_d[0]] = load_data;
      count_d                = count_d + 2'd1;
    end

    // load results clear their busy bit; a new issue to the same reg wins
    busy_d = busy_q;
    if (pop)         busy_d[buf_dest_q[0]] = 1'b0;
    else if (direct) busy_d[load_dest]     = 1'b0;
    if (load_issue)  busy_d[load_issue_dest] = 1'b1;
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      busy_q          <= '0;
      count_q         <= 2'd0;
      buf_dest_q      <= '0;
      buf_data_q      <= '0;
    end else begin
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      busy_q          <= busy_d;
      count_q         <= count_d;
      buf_dest_q      <= buf_dest_d;
      buf_data_q      <= buf_data_d;
    end
  end

  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign busy          = busy_q;
  assign stall         = (count_q == 2'd2);

`ifdef WB_BYPASS_EN
  assign bypass_hit0  = write_enable_q && (write_address_q == bypass_address0);
  assign bypass_hit1  = write_enable_q && (write_address_q == bypass_address1);
  assign bypass_data0 = bypass_hit0 ? write_data_q : '0;
  assign bypass_data1 = bypass_hit1 ? write_data_q : '0;
`endif

endmodule
